// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: fixed-latency FIFO read port -> valid/ready stream through an RD_LATENCY+1 entry skid buffer; first beat RD_LATENCY+1 cycles after data appears.
// Sink stalls are absorbed by withholding pops so the skid never overflows; FIFO_RD_STREAM_PKT_EN adds the m_last_o beat counter.
module fifo_rd_stream #(
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 1,
   parameter int PKT_LEN    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             fifo_rd_en_o,
   input  logic [WIDTH-1:0] fifo_rd_data_i,
   input  logic             fifo_rd_empty_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_last_o,
   output logic             busy_o
);
   localparam int DEPTH = RD_LATENCY + 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = CW + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [RD_LATENCY-1:0] r_inflight;
   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_occ;

   logic [RD_LATENCY-1:0] w_infl_nxt;
   logic [CW-1:0]         w_infl_cnt;
   logic [SW-1:0]         w_committed;
   logic                  w_wr;
   logic                  w_pop;
   logic                  w_rd_en;

   function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_infl_cnt    = '0;
      w_infl_nxt    = '0;
      w_infl_nxt[0] = w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) w_infl_nxt[i] = r_inflight[i-1];
      for (int i = 0; i < RD_LATENCY; i++) w_infl_cnt = w_infl_cnt + CW'(r_inflight[i]);
   end

   // Words already owed to the skid (held + in flight) after this cycle's pop must leave room for one more.
   assign w_wr        = r_inflight[RD_LATENCY-1];
   assign w_pop       = m_valid_o & m_ready_i;
   assign w_committed = SW'(r_occ) + SW'(w_infl_cnt) - SW'(w_pop);
   assign w_rd_en     = ~rst_i & ~fifo_rd_empty_i & (w_committed < SW'(DEPTH));

   assign fifo_rd_en_o = w_rd_en;
   assign m_valid_o    = (r_occ != '0);
   assign m_data_o     = r_mem[r_rd_ptr];
   assign busy_o       = m_valid_o | (|r_inflight);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_inflight <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
      end else begin
         r_inflight <= w_infl_nxt;
         if (w_wr)  r_wr_ptr <= f_ptr_next(r_wr_ptr);
         if (w_pop) r_rd_ptr <= f_ptr_next(r_rd_ptr);
         case ({w_wr, w_pop})
            2'b10:   r_occ <= r_occ + CW'(1);
            2'b01:   r_occ <= r_occ - CW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Storage carries no reset; r_occ alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (w_wr & ~rst_i) r_mem[r_wr_ptr] <= fifo_rd_data_i;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_wr && (r_occ == DEPTH_C)));
   a_params:      assert property (@(posedge clk_i) (RD_LATENCY >= 1) && (RD_LATENCY <= 4) && (PKT_LEN >= 2));

`ifdef FIFO_RD_STREAM_PKT_EN
   localparam int BW = $clog2(PKT_LEN);
   localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
   logic [BW-1:0] r_beat;

   always_ff @(posedge clk_i) begin
      if (rst_i)      r_beat <= '0;
      else if (w_pop) r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BW'(1);
   end

   assign m_last_o = m_valid_o & (r_beat == BEAT_LAST);
`else
   assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: two instances (RD_LATENCY 1 and 3) fed by a latency-accurate FIFO model.
module tb_fifo_rd_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int D0 = 2;
   localparam int D1 = 4;
`ifdef FIFO_RD_STREAM_PKT_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   logic [1:0]       rst;
   logic [1:0]       m_ready;
   wire  [1:0]       empty, rd_en, m_valid, m_last, busy;
   wire  [1:0][31:0] rd_data, m_data;

   logic [31:0] fmem [2][256];
   logic [31:0] pipe [2][4];
   int wp [2];
   int rp [2];
   int ep [2];
   int outst [2];
   int bcnt [2];
   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;

   assign empty[0]   = (wp[0] == rp[0]);
   assign empty[1]   = (wp[1] == rp[1]);
   assign rd_data[0] = pipe[0][0];
   assign rd_data[1] = pipe[1][2];

   fifo_rd_stream #(.WIDTH(32), .RD_LATENCY(1), .PKT_LEN(4)) u0 (
      .clk_i(clk), .rst_i(rst[0]), .fifo_rd_en_o(rd_en[0]), .fifo_rd_data_i(rd_data[0]),
      .fifo_rd_empty_i(empty[0]), .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]),
      .m_data_o(m_data[0]), .m_last_o(m_last[0]), .busy_o(busy[0]));

   fifo_rd_stream #(.WIDTH(32), .RD_LATENCY(3), .PKT_LEN(4)) u1 (
      .clk_i(clk), .rst_i(rst[1]), .fifo_rd_en_o(rd_en[1]), .fifo_rd_data_i(rd_data[1]),
      .fifo_rd_empty_i(empty[1]), .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]),
      .m_data_o(m_data[1]), .m_last_o(m_last[1]), .busy_o(busy[1]));

   // Upstream FIFO with read latency, plus scoreboard pointers; a reset also empties the FIFO.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
         pipe[k][0] <= rd_en[k] ? fmem[k][rp[k] % 256] : 32'hDEAD_0000;
         if (rst[k]) begin
            rp[k]    <= wp[k];
            ep[k]    <= wp[k];
            outst[k] <= 0;
            bcnt[k]  <= 0;
         end else begin
            if (rd_en[k]) rp[k] <= rp[k] + 1;
            if (m_valid[k] & m_ready[k]) begin
               ep[k]   <= ep[k] + 1;
               bcnt[k] <= (bcnt[k] + 1) % 4;
            end
            outst[k] <= outst[k] + int'(rd_en[k]) - int'(m_valid[k] & m_ready[k]);
         end
      end
   end

   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int k, input logic [31:0] v);
      fmem[k][wp[k] % 256] = v;
      wp[k] = wp[k] + 1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle checks applied every cycle to both instances.
   task automatic mid();
      @(negedge clk);
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            logic pop;
            logic exp_en;
            int   dep;
            dep    = (k == 0) ? D0 : D1;
            pop    = m_valid[k] & m_ready[k];
            exp_en = !rst[k] && !empty[k] && ((outst[k] - int'(pop)) < dep);
            chk1($sformatf("rden%0d", k), rd_en[k], exp_en);
            chk1($sformatf("busy%0d", k), busy[k], outst[k] != 0);
            chk1($sformatf("last%0d", k), m_last[k], PKT && (m_valid[k] === 1'b1) && (bcnt[k] == 3));
            if (pop === 1'b1) chk32($sformatf("data%0d", k), m_data[k], fmem[k][ep[k] % 256]);
         end
      end
   endtask

   task automatic cyc();
      mid();
      nxt();
   endtask

   initial begin
      int n;
      int base;
      rst     = 2'b11;
      m_ready = 2'b00;
      nxt();
      armed = 1'b1;
      mid();
      for (int k = 0; k < 2; k++) begin
         chk1("rst_valid", m_valid[k], 1'b0);
         chk1("rst_busy",  busy[k],    1'b0);
         chk1("rst_last",  m_last[k],  1'b0);
         chk1("rst_rden",  rd_en[k],   1'b0);
      end
      nxt();
      rst     = 2'b00;
      m_ready = 2'b11;
      cyc();

      // Latency 1: 8 preloaded words, first beat two cycles after empty falls.
      for (int i = 0; i < 8; i++) push(0, 32'(i));
      mid();
      chk1("t1_valid_c0", m_valid[0], 1'b0);
      chk1("t1_rden_c0",  rd_en[0],   1'b1);
      nxt(); mid();
      chk1("t1_valid_c1", m_valid[0], 1'b0);
      nxt(); mid();
      for (int i = 0; i < 8; i++) begin
         chk1("t1_beat_valid", m_valid[0], 1'b1);
         chk32("t1_beat_data", m_data[0], 32'(i));
         nxt(); mid();
      end
      chk1("t1_end_valid", m_valid[0], 1'b0);
      chk1("t1_end_busy",  busy[0],    1'b0);
      nxt();

      // FIFO runs dry after 5 words, 3 more arrive 10 cycles later.
      for (int i = 0; i < 5; i++) push(0, 32'h10 + i);
      repeat (12) cyc();
      for (int i = 0; i < 10; i++) begin
         mid();
         chk1("t6_gap_rden", rd_en[0], 1'b0);
         nxt();
      end
      for (int i = 5; i < 8; i++) push(0, 32'h10 + i);
      repeat (8) cyc();
      chk32("t6_beat_count", 32'(ep[0]), 32'd16);

      // Latency 3: sink stalled 20 cycles with a full FIFO.
      m_ready[1] = 1'b0;
      for (int i = 0; i < 30; i++) push(1, 32'h100 + i);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         mid();
         if (rd_en[1] === 1'b1) n++;
         if (m_valid[1] === 1'b1) chk32("t3_hold_data", m_data[1], 32'h100);
         nxt();
      end
      chk32("t3_pop_count", 32'(n), 32'd4);
      chk1("t3_held_valid", m_valid[1], 1'b1);
      m_ready[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         mid();
         chk1("t3_resume_valid", m_valid[1], 1'b1);
         nxt();
      end
      chk32("t3_beat_count", 32'(ep[1]), 32'd30);

      // 32 words with ready pattern 1,0,0,1.
      for (int i = 0; i < 32; i++) push(1, 32'h200 + i);
      n = 0;
      while (ep[1] != 62 && n < 400) begin
         m_ready[1] = ((n % 4) == 0) || ((n % 4) == 3);
         cyc();
         n++;
      end
      chk32("t2_beat_count", 32'(ep[1]), 32'd62);
      m_ready[1] = 1'b1;
      repeat (3) cyc();
      chk1("t2_idle_busy", busy[1], 1'b0);

      // Mid-operation reset with 2 words buffered and 2 reads in flight.
      m_ready[1] = 1'b0;
      for (int i = 0; i < 10; i++) push(1, 32'h300 + i);
      n = 0;
      while (n < 20) begin
         mid();
         if (m_valid[1] === 1'b1) break;
         nxt();
         n++;
      end
      chk1("t5_fill_valid", m_valid[1], 1'b1);
      nxt(); mid();
      chk1("t5_pre_busy", busy[1], 1'b1);
      chk32("t5_pre_outstanding", 32'(outst[1]), 32'd4);
      rst[1] = 1'b1;
      nxt(); mid();
      chk1("t5_rst_valid", m_valid[1], 1'b0);
      chk1("t5_rst_busy",  busy[1],    1'b0);
      chk1("t5_rst_last",  m_last[1],  1'b0);
      chk1("t5_rst_rden",  rd_en[1],   1'b0);
      rst[1] = 1'b0;
      nxt();
      for (int i = 0; i < 8; i++) begin
         mid();
         chk1("t5_no_late_data", m_valid[1], 1'b0);
         nxt();
      end
      base = wp[1];
      for (int i = 0; i < 3; i++) push(1, 32'h310 + i);
      m_ready[1] = 1'b1;
      repeat (8) cyc();
      chk32("t5_post_count", 32'(ep[1]), 32'(base + 3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter RD_LATENCY, default 1: cycles from fifo_rd_en_o high to fifo_rd_data_i valid; legal range 1..4.
REQ-003 SHALL have parameter PKT_LEN, default 16: beats per packet for m_last_o; legal range 2..65536.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port fifo_rd_en_o, output, 1: pop request to the upstream FIFO.
REQ-007 SHALL have port fifo_rd_data_i, input, WIDTH: upstream FIFO read data.
REQ-008 SHALL have port fifo_rd_empty_i, input, 1: upstream FIFO empty flag.
REQ-009 SHALL have port m_valid_o, output, 1: stream beat valid.
REQ-010 SHALL have port m_ready_i, input, 1: stream sink ready.
REQ-011 SHALL have port m_data_o, output, WIDTH: stream beat data.
REQ-012 SHALL have port m_last_o, output, 1: last beat of packet.
REQ-013 SHALL have port busy_o, output, 1: reads in flight or skid buffer non-empty.

Function
REQ-014 SHALL track in-flight reads with an RD_LATENCY-stage valid shift register; a stage exits into the skid buffer exactly RD_LATENCY cycles after its fifo_rd_en_o.
REQ-015 SHALL hold a skid buffer of DEPTH = RD_LATENCY+1 entries, circular, with pointer wrap at DEPTH (not a power of two).
REQ-016 SHALL define pop = m_valid_o & m_ready_i, and transfer a beat only on pop.
REQ-017 SHALL drive fifo_rd_en_o = ~fifo_rd_empty_i & (occupancy + inflight - pop < DEPTH); the combinational path from m_ready_i is intended.
REQ-018 SHALL guarantee that the skid buffer never overflows; a write while full is a design error and SHALL be flagged by an assertion.
REQ-019 SHALL drive m_valid_o = (occupancy != 0) and m_data_o = head entry, both from registers, with no combinational path from fifo_rd_data_i.
REQ-020 SHALL hold m_data_o and m_valid_o stable while m_valid_o & ~m_ready_i.
REQ-021 SHALL produce the first beat at m_valid_o RD_LATENCY+1 cycles after the first cycle fifo_rd_empty_i is low.
REQ-022 SHALL sustain one beat per cycle with m_ready_i held high and the FIFO non-empty.
REQ-023 SHALL, when a write arrives and a pop occurs in the same cycle, perform both, leaving occupancy unchanged.
REQ-024 SHALL keep occupancy width $clog2(DEPTH+1) and the in-flight count saturating-free by construction.
REQ-025 SHALL drive busy_o = (occupancy != 0) | (any in-flight stage set).

Reset
REQ-026 SHALL, on rst_i high at a clock edge, clear occupancy, pointers, in-flight stages and beat counter; m_valid_o=0, m_last_o=0, busy_o=0 in the following cycle.
REQ-027 SHALL hold fifo_rd_en_o=0 while rst_i is high.
REQ-028 SHALL discard data arriving for reads issued before a mid-operation reset; those words are lost, and the upstream FIFO is reset together with this block.
REQ-029 SHALL not reset the skid data storage.

Configuration
REQ-030 SHALL, with macro FIFO_RD_STREAM_PKT_EN defined, keep a beat counter 0..PKT_LEN-1, incremented on pop and wrapping to 0, and drive m_last_o = m_valid_o & (counter == PKT_LEN-1).
REQ-031 SHALL, without FIFO_RD_STREAM_PKT_EN, omit the counter and tie m_last_o to 0.

Verification
REQ-032 SHALL cover: RD_LATENCY=1, FIFO pre-loaded with 8 words 0x0..0x7, m_ready_i=1 -> m_valid_o rises 2 cycles after empty falls; 8 consecutive beats 0x0..0x7; busy_o falls afterwards.
REQ-033 SHALL cover: RD_LATENCY=3, continuous 32 words, m_ready_i toggling 1,0,0,1 repeating -> in-order data, no loss or duplication, no skid overflow assertion, fifo_rd_en_o never high while 4 words are held or in flight with no pop.
REQ-034 SHALL cover: m_ready_i=0 for 20 cycles with a full FIFO -> exactly RD_LATENCY+1 pops issued, m_data_o stable; on release, beats resume 1 per cycle.
REQ-035 SHALL cover: FIFO_RD_STREAM_PKT_EN, PKT_LEN=4, 12 beats -> m_last_o on beats 4, 8 and 12 only; without the macro m_last_o=0 throughout.
REQ-036 SHALL cover: rst_i asserted with 2 reads in flight and 2 entries buffered -> next cycle m_valid_o=0, busy_o=0; the late-arriving data is never emitted.
REQ-037 SHALL cover: the FIFO goes empty after 5 words and 3 new words arrive 10 cycles later -> 8 beats in order; fifo_rd_en_o=0 while fifo_rd_empty_i=1.
